twos_to_signmag_serial: RTL
===========================

Name: twos_to_signmag_serial

Overview:
- Converts a WIDTH-bit two's-complement word into sign-magnitude form.
- This is the inverse of the team's combinational negate (invert-plus-one) stage.
- Conversion is bit-serial, LSB-first, using the copy-until-first-one-then-invert rule. One bit is processed per clock.
- Sits between a two's-complement datapath and the sign-magnitude display/decoder logic. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 4, input word width in bits. Must be 2 or more. The magnitude output is WIDTH-1 bits.

Ports:
- clk  input  1  system clock. All state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word. High only in IDLE.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  out_sign/out_mag/out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  sign of the result (1 = negative).
- out_mag  output  WIDTH-1  magnitude.
- out_ovf  output  1  magnitude not representable. Set only for input 1 followed by WIDTH-1 zeros.
- busy  output  1  high in SHIFT and HOLD.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - Shift register, result register, bit counter and seen_one flag cleared.
  - out_valid=0, out_sign=0, out_mag=0, out_ovf=0, busy=0, in_ready=1 immediately after deassertion.
  - Reset mid-operation discards the in-flight word. No partial result is ever presented.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_data into the shift register and latch sign=in_data[WIDTH-1]. Clear the counter, seen_one and the result register, then go to SHIFT.
- SHIFT (one bit per edge, LSB first):
  - Take b = shift_reg[0].
  - If sign=0, the output bit is b.
  - If sign=1, the output bit is b when seen_one=0, and ~b when seen_one=1. Then seen_one <= seen_one | b.
  - The output bit enters the result register at the MSB end; the result register shifts right.
  - Counter increments. After the edge that processes bit WIDTH-1, go to HOLD.
- HOLD:
  - out_valid=1.
  - out_sign=sign, out_mag=result[WIDTH-2:0], out_ovf=result[WIDTH-1].
  - result[WIDTH-1] is 1 only for the most-negative input.
  - Outputs are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid. The data outputs keep their last value.
- Latency:
  - Acceptance at edge E0 gives out_valid high after edge E(WIDTH), i.e. WIDTH cycles later.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH shifts, one HOLD cycle with out_ready=1, then back in IDLE.
- in_ready is low in SHIFT and HOLD. in_valid is ignored there and no input is queued.
- Boundary cases:
  - Zero input gives sign 0, magnitude 0, ovf 0.
  - Input 1 followed by WIDTH-1 zeros gives sign 1, magnitude 0, ovf 1.
  - A positive input passes through unchanged.
  - out_ready high outside HOLD has no effect.
  - Simultaneous out_ready in HOLD and in_valid does not accept a new word that cycle.

Test Plan (WIDTH=4):
- Reset, then in_data=0101 with in_valid for 1 cycle -> in_ready drops; 4 cycles later out_valid=1, sign=0, mag=101, ovf=0.
- in_data=1011 (-5) -> sign=1, mag=101, ovf=0. Also in_data=1111 (-1) -> sign=1, mag=001.
- in_data=1000 (-8) -> sign=1, mag=000, ovf=1. Also in_data=0000 -> sign=0, mag=000, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid and outputs stable. in_valid pulses are ignored with in_ready=0. Raise out_ready -> next cycle in IDLE, in_ready=1.
- Assert rst_n=0 during the 2nd SHIFT cycle of 0110 -> outputs zero at once, out_valid never rises. After release, 1110 -> sign=1, mag=010.
- Back-to-back stream 0011, 1101, 0111, 1001 with out_ready=1 -> results sign/mag 0/011, 1/011, 0/111, 1/111, each WIDTH+2 cycles apart.

Source files
------------

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit per clock.
// Uses copy-until-first-one-then-invert; valid/ready handshake on input and output.
module twos_to_signmag_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-2:0] out_mag,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a word transfers on a rising edge where valid and ready are
  // both high; valid holds with stable data until that edge, ready never
  // waits on valid.

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             sign;

  logic             out_bit;
  logic [WIDTH-1:0] result_next;

  // Negative words copy bits up to and including the first one, then invert.
  always_comb begin
    out_bit     = shift_reg[0];
    if (sign && seen_one) out_bit = ~shift_reg[0];
    result_next = {out_bit, result[WIDTH-1:1]};
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      result    <= '0;
      cnt       <= '0;
      seen_one  <= 1'b0;
      sign      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            sign      <= in_data[WIDTH-1];
            cnt       <= '0;
            seen_one  <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
          result    <= result_next;
          seen_one  <= seen_one | shift_reg[0];
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            // Output registers load from the final shifted result.
            out_valid <= 1'b1;
            out_sign  <= sign;
            out_mag   <= result_next[WIDTH-2:0];
            out_ovf   <= result_next[WIDTH-1];
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
